// File: rtl/iob_fifo_read_ptr_ctrl.sv
// ----------------------------------------------------------------------------
// iob_fifo_read_ptr_ctrl
//
// Read-side pointer controller of the dual-clock FIFO. Synchronizes the write
// domain Gray pointer into the read clock domain, converts it to binary and
// keeps the binary and Gray read pointers. Drives the RAM read port, the empty
// flag and the fill level, and returns the registered Gray read pointer to the
// write domain.
//
// Ports:
//   clk_i       read-domain clock, rising edge
//   cke_i       clock enable; 0 freezes every register
//   arst_n_i    asynchronous reset, active-low
//   rst_i       synchronous soft reset, active-high, gated by cke_i
//   r_en_i      pop request
//   w_gray_i    write pointer in Gray code (asynchronous to clk_i)
//   r_gray_o    registered Gray read pointer for the write domain
//   r_addr_o    RAM read address
//   r_mem_en_o  RAM read enable (accepted pop)
//   r_empty_o   FIFO empty flag
//   r_level_o   number of entries available, 0 .. 2**ADDR_W
// ----------------------------------------------------------------------------
module iob_fifo_read_ptr_ctrl #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_n_i,
    input  logic              rst_i,
    input  logic              r_en_i,
    input  logic [ADDR_W:0]   w_gray_i,
    output logic [ADDR_W:0]   r_gray_o,
    output logic [ADDR_W-1:0] r_addr_o,
    output logic              r_mem_en_o,
    output logic              r_empty_o,
    output logic [ADDR_W:0]   r_level_o
);

    localparam int unsigned PtrW = ADDR_W + 1;

    // Stage 0 samples w_gray_i; stage SYNC_STAGES-1 is the synchronized value.
    logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
    logic [ADDR_W:0]                  rptr_bin_q;
    logic [ADDR_W:0]                  r_gray_q;

    logic [ADDR_W:0] w_gray_s;
    logic [ADDR_W:0] w_bin_s;
    logic [ADDR_W:0] rptr_inc;
    logic [ADDR_W:0] rgray_inc;
    logic            empty;
    logic            pop;

    assign w_gray_s = sync_q[SYNC_STAGES-1];

    // Binary bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        w_bin_s = '0;
        for (int i = 0; i < PtrW; i++) begin
            w_bin_s[i] = ^(w_gray_s >> i);
        end
    end

    assign rptr_inc  = rptr_bin_q + {{ADDR_W{1'b0}}, 1'b1};
    assign rgray_inc = rptr_inc ^ (rptr_inc >> 1);

    assign empty = (r_gray_q == w_gray_s);
    assign pop   = r_en_i & ~empty & cke_i;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q     <= '0;
            rptr_bin_q <= '0;
            r_gray_q   <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                // Soft reset wins over a pop issued in the same cycle.
                sync_q     <= '0;
                rptr_bin_q <= '0;
                r_gray_q   <= '0;
            end else begin
                if (SYNC_STAGES > 1) begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], w_gray_i};
                end else begin
                    sync_q <= w_gray_i;
                end
                if (pop) begin
                    rptr_bin_q <= rptr_inc;
                    r_gray_q   <= rgray_inc;
                end
            end
        end
    end

    assign r_gray_o   = r_gray_q;
    assign r_addr_o   = rptr_bin_q[ADDR_W-1:0];
    assign r_mem_en_o = pop;
    assign r_empty_o  = empty;
    assign r_level_o  = w_bin_s - rptr_bin_q;

endmodule
